spi_rx_deser: RTL and testbench
===============================

Name: spi_rx_deser

Overview:
- Mode-0 SPI slave receive deserializer; the upstream neighbour of the data-valid set/clear flag.
- Oversamples the external SCK/MOSI/CS_N pins on the system clock and assembles DATA_W-bit words.
- Presents each completed word on rx_data with a one-cycle rx_done pulse; rx_done drives the flag's set input.
- Reports overrun (word completes while the flag is still set) and frame abort (CS_N deasserted mid-word).

Parameters:
- DATA_W, 8, word width in bits; legal range 2..32.
- SYNC_STAGES, 2, synchronizer depth for each pin input; legal range 2..4.
- MSB_FIRST, 1, 1 = first received bit lands in rx_data[DATA_W-1]; 0 = first bit lands in rx_data[0].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock pin; asynchronous to clk; idles low (mode 0).
- spi_mosi  in  1  serial data pin; asynchronous.
- spi_cs_n  in  1  chip select pin; active low; asynchronous.
- rx_valid_in  in  1  current state of the downstream data-valid flag; used only for overrun detection.
- rx_data  out  DATA_W  last completed word; held until the next word completes.
- rx_done  out  1  one-cycle pulse: rx_data updated this cycle.
- rx_overrun  out  1  one-cycle pulse: rx_done fired while rx_valid_in=1.
- frame_err  out  1  one-cycle pulse: CS_N rose with a partial word pending.

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - rx_data=0, rx_done=0, rx_overrun=0, frame_err=0.
  - Synchronizer chains reset to sck=0, mosi=0, cs_n=1.
  - State = IDLE; bit_cnt=0; shift register = 0.
- Synchronization: each pin passes through SYNC_STAGES flops. sck_d holds the previous synchronized SCK; sck_rise = sck_s & ~sck_d.
- State IDLE:
  - Synchronized cs_n = 0 → go to ACTIVE, bit_cnt=0, shift register cleared.
  - SCK edges in IDLE are ignored.
- State ACTIVE, on sck_rise:
  - Shift in the synchronized MOSI bit (direction set by MSB_FIRST); bit_cnt++.
  - When the accepted bit is number DATA_W-1: load rx_data with the full word, pulse rx_done, reset bit_cnt to 0, stay ACTIVE.
  - Back-to-back words within one CS frame need no idle gap.
- State ACTIVE, on synchronized cs_n = 1 → go to IDLE.
  - If bit_cnt != 0 after any same-cycle SCK processing: frame_err pulse; partial word discarded; rx_data unchanged.
- Simultaneous sck_rise and cs_n rise in the same cycle:
  - The SCK bit is accepted first, then CS is evaluated.
  - If that bit completes the word: rx_done fires and there is no frame_err.
- Overrun:
  - rx_overrun=1 in the same cycle as rx_done when rx_valid_in=1.
  - rx_data is still overwritten (newest data wins).
- Latency: count the first clk edge that samples the final SCK high as edge 0. rx_done is high in the cycle after edge SYNC_STAGES.
- Timing constraints:
  - SCK high and low times must each be ≥ 2 clk periods.
  - MOSI must be stable ≥ 1 clk period before and after each SCK rise.
  - Violations are outside spec.
- Counter width: bit_cnt is $clog2(DATA_W) bits; it never exceeds DATA_W-1.
- Reset asserted mid-word: all state cleared immediately; no pulses are emitted on reset release.

Decomposition:
- Shared package:
  - State enum {IDLE, ACTIVE}.
  - Default DATA_W and SYNC_STAGES constants.
  - Shared so the downstream flag and register blocks use the same width.
- Sub-module: pin_sync (SYNC_STAGES-deep flop chain with parameterised reset value), instantiated three times (sck, mosi, cs_n).

Test Plan:
- CS_N low, send 0xA5 MSB-first (8 SCK rises), rx_valid_in=0 → one rx_done pulse, rx_data=0xA5, rx_overrun=0, frame_err=0.
- One CS frame carrying 0x3C then 0xC3 with no gap → two rx_done pulses; rx_data=0x3C after the first, 0xC3 after the second.
- Send 5 bits, then raise CS_N → frame_err pulses once, no rx_done, rx_data keeps its previous value.
- Send 0x81 with rx_valid_in held at 1 → rx_done and rx_overrun pulse in the same cycle, rx_data=0x81.
- MSB_FIRST=0, send bit sequence 1,0,0,0,0,0,0,0 → rx_data=0x01.
- Assert rst_n=0 after 4 bits, release, then send a full 0x5A → no spurious pulses after release, rx_data=0x5A after the word.

Source files
------------

// File: rtl/spi_rx_deser_pkg.sv
// Shared types and defaults for the SPI receive path.
// Used by the deserializer and by the downstream flag/register blocks so
// that everyone agrees on the word width.
package spi_rx_deser_pkg;

    // Receiver frame state.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_DATA_W      = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage : spi_rx_deser_pkg

// File: rtl/spi_rx_deser_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous pin input
//   q          : synchronized output (last flop of the chain)
module spi_rx_deser_pin_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; reset to the pin's idle level so no edge is seen on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : spi_rx_deser_pin_sync

// File: rtl/spi_rx_deser.sv
// Mode-0 SPI slave receive deserializer.
// Oversamples SCK/MOSI/CS_N on clk and assembles DATA_W-bit words.
// Ports:
//   clk, rst_n             : system clock, async active-low reset
//   spi_sck/mosi/cs_n      : raw SPI pins (asynchronous)
//   rx_valid_in            : downstream data-valid flag, for overrun detection
//   rx_data                : last completed word, held until the next one
//   rx_done                : 1-cycle pulse, rx_data updated
//   rx_overrun             : 1-cycle pulse, word completed while flag still set
//   frame_err              : 1-cycle pulse, CS_N rose with a partial word
module spi_rx_deser
    import spi_rx_deser_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    input  logic              rx_valid_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_overrun,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic sck_s, mosi_s, cs_s;
    logic sck_d;
    logic sck_rise_c;

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, sh_nxt, sh_shifted_c;
    logic [DATA_W-1:0] data_nxt;
    logic              done_nxt, ovr_nxt, ferr_nxt;

    spi_rx_deser_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(spi_sck), .q(sck_s)
    );
    spi_rx_deser_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
    );
    spi_rx_deser_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s)
    );

    assign sck_rise_c = sck_s & ~sck_d;

    // Shift direction is fixed at elaboration.
    assign sh_shifted_c = MSB_FIRST ? {shreg[DATA_W-2:0], mosi_s}
                                    : {mosi_s, shreg[DATA_W-1:1]};

    // State, datapath and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sck_d      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sck_d      <= sck_s;
            bit_cnt    <= cnt_nxt;
            shreg      <= sh_nxt;
            rx_data    <= data_nxt;
            rx_done    <= done_nxt;
            rx_overrun <= ovr_nxt;
            frame_err  <= ferr_nxt;
        end
    end

    // Next-state logic. The SCK bit is taken before CS is evaluated, so a
    // word completed in the same cycle CS rises is delivered without error.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sh_nxt    = shreg;
        data_nxt  = rx_data;
        done_nxt  = 1'b0;
        ovr_nxt   = 1'b0;
        ferr_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                    sh_nxt    = '0;
                end
            end
            ACTIVE: begin
                if (sck_rise_c) begin
                    sh_nxt = sh_shifted_c;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        data_nxt = sh_shifted_c;
                        done_nxt = 1'b1;
                        ovr_nxt  = rx_valid_in;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
                if (cs_s) begin
                    state_nxt = IDLE;
                    ferr_nxt  = (cnt_nxt != '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule : spi_rx_deser

// File: tb/tb_spi_rx_deser.sv
// Self-checking bench for spi_rx_deser: scoreboard of expected words,
// monitor compares on each rx_done; per-scenario tasks check pulse counts.
module tb_spi_rx_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sck, spi_mosi, spi_cs_n, rx_valid_in;
    logic [7:0] rx_data, lsb_data;
    logic       rx_done, rx_overrun, frame_err;
    logic       lsb_done, lsb_overrun, lsb_ferr;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    spi_rx_deser #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .rx_valid_in(rx_valid_in), .rx_data(rx_data),
        .rx_done(rx_done), .rx_overrun(rx_overrun), .frame_err(frame_err)
    );

    spi_rx_deser #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .rx_valid_in(rx_valid_in), .rx_data(lsb_data),
        .rx_done(lsb_done), .rx_overrun(lsb_overrun), .frame_err(lsb_ferr)
    );

    // Scoreboard monitor on the MSB-first instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done) begin
                done_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_done: rx_data=%h, no word expected", rx_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (rx_data !== e.data) begin
                        failures++;
                        $display("FAIL sb_data: got %h expected %h", rx_data, e.data);
                    end
                    checks++;
                    if (rx_overrun !== e.ovr) begin
                        failures++;
                        $display("FAIL sb_overrun: got %b expected %b", rx_overrun, e.ovr);
                    end
                end
            end else if (rx_overrun) begin
                checks++;
                failures++;
                $display("FAIL overrun_without_done: got 1 expected 0");
            end
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk); #2;
        spi_mosi = b;
        repeat (2) @(posedge clk); #2;
        spi_sck = 1'b1;
        repeat (4) @(posedge clk); #2;
        spi_sck = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        sb_q.push_back('{data: w, ovr: rx_valid_in});
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic cs_low();
        @(posedge clk); #2;
        spi_cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(posedge clk); #2;
        spi_cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; rx_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++;
        if ({rx_done, rx_overrun, frame_err} !== 3'b000) begin
            failures++; $display("FAIL reset_pulses: got %b expected 000", {rx_done, rx_overrun, frame_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // 0xA5 MSB-first, with an explicit latency check on the last bit.
    task automatic test_basic();
        int d0;
        logic [7:0] w = 8'hA5;
        cs_low();
        d0 = done_cnt;
        sb_q.push_back('{data: w, ovr: 1'b0});
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        @(posedge clk); #2;
        spi_mosi = w[0];
        repeat (2) @(posedge clk); #2;
        spi_sck = 1'b1;
        repeat (2) @(posedge clk); #1;   // after edge 1
        checks++;
        if (rx_done !== 1'b0) begin failures++; $display("FAIL latency_early: rx_done got %b expected 0", rx_done); end
        @(posedge clk); #1;              // after edge 2
        checks++;
        if (rx_done !== 1'b1) begin failures++; $display("FAIL latency_done: rx_done got %b expected 1", rx_done); end
        repeat (2) @(posedge clk); #2;
        spi_sck = 1'b0;
        cs_high();
        checks++;
        if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        int d0;
        cs_low();
        d0 = done_cnt;
        send_word(8'h3C);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (rx_data !== 8'h3C) begin failures++; $display("FAIL b2b_first: got %h expected 3c", rx_data); end
        send_word(8'hC3);
        cs_high();
        checks++;
        if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
        checks++;
        if (rx_data !== 8'hC3) begin failures++; $display("FAIL b2b_second: got %h expected c3", rx_data); end
    endtask

    task automatic test_frame_err();
        int d0, f0;
        cs_low();
        d0 = done_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        cs_high();
        checks++;
        if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        checks++;
        if (done_cnt - d0 !== 0) begin failures++; $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0); end
        checks++;
        if (rx_data !== 8'hC3) begin failures++; $display("FAIL ferr_data_held: got %h expected c3", rx_data); end
    endtask

    task automatic test_overrun();
        rx_valid_in = 1'b1;
        cs_low();
        send_word(8'h81);
        cs_high();
        rx_valid_in = 1'b0;
        checks++;
        if (rx_data !== 8'h81) begin failures++; $display("FAIL overrun_data: got %h expected 81", rx_data); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] bits = 8'b1000_0000;   // sent first-to-last: 1,0,0,0,0,0,0,0
        sb_q.push_back('{data: bits, ovr: 1'b0});
        cs_low();
        for (int i = 7; i >= 0; i--) send_bit(bits[i]);
        cs_high();
        checks++;
        if (lsb_data !== 8'h01) begin failures++; $display("FAIL lsb_first_data: got %h expected 01", lsb_data); end
    endtask

    task automatic test_mid_reset();
        int d0, f0;
        cs_low();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rx_data !== 8'h00) begin failures++; $display("FAIL midreset_data: got %h expected 00", rx_data); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        d0 = done_cnt; f0 = ferr_cnt;
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin
            failures++; $display("FAIL midreset_spurious: got %0d pulses expected 0", (done_cnt - d0) + (ferr_cnt - f0));
        end
        send_word(8'h5A);
        cs_high();
        checks++;
        if (rx_data !== 8'h5A) begin failures++; $display("FAIL midreset_data_after: got %h expected 5a", rx_data); end
        checks++;
        if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL midreset_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_lsb_first();
        test_mid_reset();
        repeat (5) @(posedge clk);
        checks++;
        if (sb_q.size() !== 0) begin
            failures++; $display("FAIL sb_leftover: got %0d pending words expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_rx_deser
